// File: rtl/cube_motor_sequencer.sv
// Cube solver face-turn sequencer.
// Decodes one turn command byte from the HPS motor_control PIO and drives
// step/direction/enable for the six face stepper drivers, one turn at a time.
// A turn is: enable the selected driver, wait for it to settle, then emit
// `target` step pulses with equal high and low times, then release the driver.

module cube_motor_sequencer #(
    parameter int STEP_DIV      = 25000,
    parameter int STEPS_QUARTER = 50,
    parameter int SETTLE_CYCLES = 50000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] motor_control,
    output logic [5:0] motor_step,
    output logic [5:0] motor_dir,
    output logic [5:0] motor_en_n,
    output logic       busy,
    output logic       done_pulse,
    output logic       error
);

    // One shared timer serves both the settle wait and the step half-periods.
    localparam int TIMER_MAX = (SETTLE_CYCLES > STEP_DIV) ? SETTLE_CYCLES : STEP_DIV;
    localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int SW        = $clog2(2 * STEPS_QUARTER + 1);

    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] STEP_LAST   = TW'(STEP_DIV - 1);
    localparam logic [SW-1:0] TGT_QUARTER = SW'(STEPS_QUARTER);
    localparam logic [SW-1:0] TGT_HALF    = SW'(2 * STEPS_QUARTER);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        STEP_HI = 3'd2,
        STEP_LO = 3'd3,
        DONE    = 3'd4
    } state_e;

    // One-hot driver select for a face index (faces 6/7 never reach here).
    function automatic logic [5:0] face_onehot(input logic [2:0] f);
        return 6'b000001 << f;
    endfunction

    // Reserved command bits carry no meaning for this block.
    logic unused_ctrl_s;
    assign unused_ctrl_s = ^motor_control[6:5];

    // Input capture
    logic [4:0]    cmd_q;
    logic          go_q;
    logic          go_prev_q;
    logic          go_edge_s;

    // Turn state
    state_e        state_q,    state_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [SW-1:0] target_q,   target_d;
    logic [2:0]    face_q,     face_d;
    logic          dir_q,      dir_d;

    // Registered outputs
    logic [5:0]    step_q,     step_d;
    logic [5:0]    dir_out_q,  dir_out_d;
    logic [5:0]    en_n_q,     en_n_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          error_q,    error_d;
    logic          active_s;

    assign go_edge_s = go_q & ~go_prev_q;

    // Register the command byte once and keep the previous go bit for edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_q     <= 5'd0;
            go_q      <= 1'b0;
            go_prev_q <= 1'b0;
        end else begin
            cmd_q     <= motor_control[4:0];
            go_q      <= motor_control[7];
            go_prev_q <= go_q;
        end
    end

    // Next-state, counters and latched turn parameters.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        step_cnt_d = step_cnt_q;
        target_d   = target_q;
        face_d     = face_q;
        dir_d      = dir_q;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                if (go_edge_s) begin
                    if (cmd_q[2:0] <= 3'd5) begin
                        face_d     = cmd_q[2:0];
                        dir_d      = cmd_q[3];
                        target_d   = cmd_q[4] ? TGT_HALF : TGT_QUARTER;
                        timer_d    = {TW{1'b0}};
                        step_cnt_d = {SW{1'b0}};
                        error_d    = 1'b0;
                        state_d    = SETTLE;
                    end else begin
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = {TW{1'b0}};
                    state_d = STEP_HI;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STEP_HI: begin
                if (timer_q == STEP_LAST) begin
                    timer_d = {TW{1'b0}};
                    state_d = STEP_LO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STEP_LO: begin
                if (timer_q == STEP_LAST) begin
                    timer_d    = {TW{1'b0}};
                    step_cnt_d = step_cnt_q + SW'(1);
                    if (step_cnt_d == target_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = STEP_HI;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                step_cnt_d = {SW{1'b0}};
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so that
    // the registered outputs line up with the state register.
    always_comb begin
        active_s  = (state_d == SETTLE) || (state_d == STEP_HI) || (state_d == STEP_LO);
        step_d    = 6'b000000;
        dir_out_d = 6'b000000;
        en_n_d    = 6'b111111;
        busy_d    = active_s;
        done_d    = (state_d == DONE);
        if (active_s) begin
            en_n_d = ~face_onehot(face_d);
            if (dir_d) begin
                dir_out_d = face_onehot(face_d);
            end else begin
                dir_out_d = 6'b000000;
            end
            if (state_d == STEP_HI) begin
                step_d = face_onehot(face_d);
            end else begin
                step_d = 6'b000000;
            end
        end else begin
            en_n_d = 6'b111111;
        end
    end

    // State, counter and output registers; reset abandons any turn in flight.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            timer_q    <= {TW{1'b0}};
            step_cnt_q <= {SW{1'b0}};
            target_q   <= {SW{1'b0}};
            face_q     <= 3'd0;
            dir_q      <= 1'b0;
            step_q     <= 6'b000000;
            dir_out_q  <= 6'b000000;
            en_n_q     <= 6'b111111;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            step_cnt_q <= step_cnt_d;
            target_q   <= target_d;
            face_q     <= face_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            dir_out_q  <= dir_out_d;
            en_n_q     <= en_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign motor_step = step_q;
    assign motor_dir  = dir_out_q;
    assign motor_en_n = en_n_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_cube_motor_sequencer.sv
// Self-checking bench for cube_motor_sequencer with small timing parameters.
// Each accepted turn pushes its expected outcome to a scoreboard queue; a
// negedge monitor measures the turn and compares when done_pulse appears.

module tb_cube_motor_sequencer;

    localparam int STEP_DIV      = 4;
    localparam int STEPS_QUARTER = 3;
    localparam int SETTLE_CYCLES = 5;

    logic       clk_clk;
    logic       reset_reset_n;
    logic [7:0] motor_control;
    logic [5:0] motor_step;
    logic [5:0] motor_dir;
    logic [5:0] motor_en_n;
    logic       busy;
    logic       done_pulse;
    logic       error;

    cube_motor_sequencer #(
        .STEP_DIV      (STEP_DIV),
        .STEPS_QUARTER (STEPS_QUARTER),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .motor_control (motor_control),
        .motor_step    (motor_step),
        .motor_dir     (motor_dir),
        .motor_en_n    (motor_en_n),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .error         (error)
    );

    typedef struct {
        int face;
        int dir;
        int steps;
    } exp_t;

    exp_t sb_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // Monitor state
    int         done_cnt = 0;
    int         busy_cnt = 0;
    int         pulses[6];
    int         hi_run[6];
    logic [5:0] en_seen   = 6'h3f;
    logic [5:0] dir_seen  = 6'h00;
    logic [5:0] step_prev = 6'h00;
    logic       drift     = 1'b0;
    logic       busy_prev = 1'b0;
    logic       done_prev = 1'b0;

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_turn(input int face, input int dir, input int half);
        exp_t e;
        e.face  = face;
        e.dir   = dir;
        e.steps = half ? 2 * STEPS_QUARTER : STEPS_QUARTER;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [7:0] v);
        @(posedge clk_clk);
        #1 motor_control = v;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 300) begin
            @(posedge clk_clk);
            t++;
        end
        check_eq("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic clear_stats();
        busy_cnt  = 0;
        drift     = 1'b0;
        en_seen   = 6'h3f;
        dir_seen  = 6'h00;
        for (int f = 0; f < 6; f++) begin
            pulses[f] = 0;
            hi_run[f] = 0;
        end
    endtask

    // Negedge monitor: measures each turn and scores it against the queue at done_pulse.
    initial begin
        exp_t e;
        int   others;
        clear_stats();
        forever begin
            @(negedge clk_clk);
            if (!reset_reset_n) begin
                clear_stats();
                step_prev = 6'h00;
                busy_prev = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (busy) begin
                    if (busy_cnt == 0) begin
                        en_seen  = motor_en_n;
                        dir_seen = motor_dir;
                    end else if (motor_en_n !== en_seen || motor_dir !== dir_seen) begin
                        drift = 1'b1;
                    end
                    busy_cnt++;
                end
                for (int f = 0; f < 6; f++) begin
                    if (motor_step[f] && !step_prev[f]) pulses[f]++;
                    if (motor_step[f]) begin
                        hi_run[f]++;
                    end else if (step_prev[f]) begin
                        check_eq("step_hi_width", 32'(hi_run[f]), 32'(STEP_DIV));
                        hi_run[f] = 0;
                    end
                end
                step_prev = motor_step;
                if (done_pulse) begin
                    done_cnt++;
                    check_eq("done_follows_busy", 32'(busy_prev), 32'd1);
                    check_eq("done_one_cycle", 32'(done_prev), 32'd0);
                    check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check_eq("busy_len", 32'(busy_cnt), 32'(SETTLE_CYCLES + 2 * STEP_DIV * e.steps));
                        check_eq("step_count", 32'(pulses[e.face]), 32'(e.steps));
                        others = 0;
                        for (int f = 0; f < 6; f++) begin
                            if (f != e.face) others += pulses[f];
                        end
                        check_eq("idle_face_steps", 32'(others), 32'd0);
                        check_eq("en_during_turn", 32'(en_seen), 32'(6'h3f & ~(6'd1 << e.face)));
                        check_eq("dir_during_turn", 32'(dir_seen), 32'(e.dir != 0 ? (6'd1 << e.face) : 6'd0));
                        check_eq("outputs_stable", 32'(drift), 32'd0);
                    end
                    check_eq("en_after_done", 32'(motor_en_n), 32'h3f);
                    check_eq("dir_after_done", 32'(motor_dir), 32'h00);
                    check_eq("busy_at_done", 32'(busy), 32'd0);
                    clear_stats();
                end
                busy_prev = busy;
                done_prev = done_pulse;
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int base;
        int t;
        reset_reset_n = 1'b0;
        motor_control = 8'h00;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_eq("rst_step", 32'(motor_step), 32'h00);
        check_eq("rst_dir", 32'(motor_dir), 32'h00);
        check_eq("rst_en_n", 32'(motor_en_n), 32'h3f);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done_pulse), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        reset_reset_n = 1'b1;
        repeat (2) @(posedge clk_clk);

        // 1. Quarter turn face 0 CW, with start latency check.
        push_turn(0, 1, 0);
        drive(8'h88);
        @(negedge clk_clk);
        @(negedge clk_clk);
        check_eq("busy_before_detect", 32'(busy), 32'd0);
        @(negedge clk_clk);
        check_eq("busy_after_detect", 32'(busy), 32'd1);
        check_eq("en_after_detect", 32'(motor_en_n), 32'h3e);
        check_eq("dir_after_detect", 32'(motor_dir), 32'h01);
        wait_done(1);
        drive(8'h00);
        repeat (2) @(posedge clk_clk);

        // 2. Half turn face 5 CCW.
        push_turn(5, 0, 1);
        drive(8'h95);
        wait_done(2);
        drive(8'h00);
        repeat (2) @(posedge clk_clk);

        // 3. Invalid face sets error; a valid go clears it and starts face 2.
        drive(8'h87);
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_eq("err_set", 32'(error), 32'd1);
        check_eq("err_busy", 32'(busy), 32'd0);
        check_eq("err_en_n", 32'(motor_en_n), 32'h3f);
        check_eq("err_step", 32'(motor_step), 32'h00);
        check_eq("err_dir", 32'(motor_dir), 32'h00);
        drive(8'h00);
        repeat (2) @(posedge clk_clk);
        push_turn(2, 0, 0);
        drive(8'h82);
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        check_eq("err_cleared", 32'(error), 32'd0);
        check_eq("err_then_busy", 32'(busy), 32'd1);
        wait_done(3);
        drive(8'h00);
        repeat (2) @(posedge clk_clk);

        // 4. A second go edge mid-turn is ignored.
        push_turn(0, 1, 0);
        drive(8'h88);
        repeat (10) @(posedge clk_clk);
        drive(8'h08);
        repeat (3) @(posedge clk_clk);
        drive(8'h83);
        wait_done(4);
        repeat (10) @(posedge clk_clk);
        @(negedge clk_clk);
        check_eq("ignored_go_busy", 32'(busy), 32'd0);
        check_eq("ignored_go_dones", 32'(done_cnt), 32'd4);
        drive(8'h00);
        repeat (2) @(posedge clk_clk);

        // 5. Reset during STEP_HI abandons the turn.
        base = done_cnt;
        drive(8'h88);
        t = 0;
        @(negedge clk_clk);
        while (!motor_step[0] && t < 60) begin
            @(negedge clk_clk);
            t++;
        end
        check_eq("reached_step_hi", 32'(motor_step[0]), 32'd1);
        #2 reset_reset_n = 1'b0;
        #1;
        check_eq("async_rst_step", 32'(motor_step), 32'h00);
        check_eq("async_rst_en_n", 32'(motor_en_n), 32'h3f);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_done", 32'(done_pulse), 32'd0);
        repeat (3) @(posedge clk_clk);
        motor_control = 8'h00;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (5) @(posedge clk_clk);
        check_eq("no_done_after_rst", 32'(done_cnt), 32'(base));
        push_turn(1, 0, 0);
        drive(8'h81);
        wait_done(base + 1);
        drive(8'h00);
        repeat (2) @(posedge clk_clk);

        // 6. Go held high across the turn gives exactly one turn.
        base = done_cnt;
        push_turn(0, 1, 0);
        drive(8'h88);
        wait_done(base + 1);
        repeat (40) @(posedge clk_clk);
        @(negedge clk_clk);
        check_eq("held_go_dones", 32'(done_cnt), 32'(base + 1));
        check_eq("held_go_busy", 32'(busy), 32'd0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
